// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a start/busy/done handshake.
// Optional leading-zero blank mask is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W     = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [W-1:0]       adj;
  logic [W-1:0]       shifted;
  logic               final_ovf;

  // Per-digit add-3 on the BCD field only; digits never carry into each other.
  function automatic logic [W-1:0] add3(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[BIN_W+4*k +: 4];
      if (d >= 4'd5) r[BIN_W+4*k +: 4] = d + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;

  // Digit k is blanked when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] d);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'd0) zero_above = 1'b0;
      m[k] = zero_above;
    end
    return m;
  endfunction
`endif

  assign adj       = add3(sr_q);
  assign shifted   = {adj[W-2:0], 1'b0};
  assign final_ovf = sticky_q | adj[W-1];

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank_d  = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d     = {{BCD_W{1'b0}}, bin_in};
          cnt_d    = CNT_W'(BIN_W);
          sticky_d = 1'b0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d     = shifted;
        sticky_d = final_ovf;
        cnt_d    = cnt_q - CNT_W'(1);
        // Result lands on the last iteration edge so it is valid throughout the done cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          ovf_d   = final_ovf;
          bcd_d   = final_ovf ? {DIGITS{4'h9}} : shifted[W-1:BIN_W];
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_d = final_ovf ? '0 : blank_mask(shifted[W-1:BIN_W]);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign blank    = blank_q;
`else
  assign blank    = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 3-digit instance and a 2-digit overflow instance.
// Blank expectations follow BCD_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [7:0]  bin_in, bin2;
  logic        busy, done, overflow;
  logic [11:0] bcd_out;
  logic [2:0]  blank;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [1:0]  blank2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  blank;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  exp_t e_m, e_m2;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow), .blank(blank)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2), .blank(blank2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v, input int nd);
    exp_t e;
    int   p;
    e.bcd   = '0;
    e.ovf   = 1'b0;
    e.blank = '0;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * 10;
    if (v > p - 1) begin
      e.ovf = 1'b1;
      for (int k = 0; k < nd; k++) e.bcd[4*k +: 4] = 4'h9;
    end else begin
      p = 1;
      for (int k = 0; k < nd; k++) begin
        e.bcd[4*k +: 4] = 4'((v / p) % 10);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (k >= 1 && v < p) e.blank[k] = 1'b1;
`endif
        p = p * 10;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e_m = q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e_m.bcd));
        chk("overflow", 32'(overflow), 32'(e_m.ovf));
        chk("blank", 32'(blank), 32'(e_m.blank));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("spurious_done2", 1, 0);
      else begin
        e_m2 = q2.pop_front();
        chk("bcd_out2", 32'(bcd2), 32'(e_m2.bcd[7:0]));
        chk("overflow2", 32'(ovf2), 32'(e_m2.ovf));
        chk("blank2", 32'(blank2), 32'(e_m2.blank[1:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (the cycle after the accept edge).
  task automatic start_conv(input int v);
    bin_in = 8'(v);
    start  = 1'b1;
    q.push_back(model(v, 3));
    step();
    start  = 1'b0;
  endtask

  task automatic start_conv2(input int v);
    bin2   = 8'(v);
    start2 = 1'b1;
    q2.push_back(model(v, 2));
    step();
    start2 = 1'b0;
  endtask

  // Returns in the first idle cycle after the done cycle (earliest legal accept).
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    step();
  endtask

  task automatic wait_done2();
    int n = 0;
    while (!done2 && n < 40) begin
      step();
      n++;
    end
    if (!done2) chk("done2_timeout", 0, 1);
    step();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    bin_in = '0;
    bin2   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_blank", 32'(blank), 0);
    step();

    // Latency of a conversion of 0: done exactly in cycle 9, busy for cycles 1..9.
    start_conv(0);
    for (int n = 1; n <= 10; n++) begin
      chk($sformatf("lat_busy_c%0d", n), 32'(busy), 32'(n <= 9));
      chk($sformatf("lat_done_c%0d", n), 32'(done), 32'(n == 9));
      step();
    end

    // Back-to-back at the earliest legal accept.
    start_conv(255);
    wait_done();
    chk("b2b_idle", 32'(busy), 0);
    start_conv(99);
    wait_done();
    start_conv(7);
    wait_done();
    chk("b2b_last", 32'(bcd_out), 32'h007);

    // Starts during SHIFT (cycle 3) and DONE (cycle 9) are ignored.
    start_conv(128);
    for (int n = 1; n <= 12; n++) begin
      if (n == 3 || n == 9) begin
        start  = 1'b1;
        bin_in = 8'd5;
      end else begin
        start  = 1'b0;
      end
      chk($sformatf("ign_done_c%0d", n), 32'(done), 32'(n == 9));
      step();
    end
    chk("ign_bcd", 32'(bcd_out), 32'h128);
    chk("ign_busy", 32'(busy), 0);

    // Reset mid-conversion discards the partial result.
    start_conv(42);
    wait_done();
    chk("pre_rst_bcd", 32'(bcd_out), 32'h042);
    start_conv(200);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_bcd", 32'(bcd_out), 0);
    for (int n = 0; n < 15; n++) begin
      chk("post_rst_nodone", 32'(done), 0);
      step();
    end
    start_conv(13);
    wait_done();
    chk("post_rst_bcd", 32'(bcd_out), 32'h013);

    // Leading-zero blank mask.
    start_conv(7);
    wait_done();
    start_conv(0);
    wait_done();
    start_conv(40);
    wait_done();
    start_conv(255);
    wait_done();

    // Two-digit instance: saturation on overflow, then an exact 99.
    start_conv2(100);
    wait_done2();
    chk("d2_ovf_flag", 32'(ovf2), 1);
    chk("d2_ovf_bcd", 32'(bcd2), 32'h99);
    start_conv2(99);
    wait_done2();
    chk("d2_99_flag", 32'(ovf2), 0);
    chk("d2_99_bcd", 32'(bcd2), 32'h99);

    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 0);
    chk("queue2_empty", 32'(q2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
